// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_LIM_DEF = 4;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter, bundled as one interface.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side: serves the requesters and drives the memory.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: requesters plus memory.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_sat_counter32.sv
// 32-bit event counter that sticks at all-ones; used by the arbiter's
// MEM_PORT_ARBITER_PERF_EN statistics.
module sat_counter32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and data requesters.
// Optional grant/conflict counters are built when MEM_PORT_ARBITER_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]  perf_if_gnts,
  output logic [31:0]  perf_dm_gnts,
  output logic [31:0]  perf_conflicts
`endif
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;

  logic             if_rvalid_q, if_rvalid_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic             dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0]    dm_rdata_q, dm_rdata_d;

  logic             starve_c;
  logic             grant_dm_c;
  logic             grant_if_c;

  // Data wins ties unless fetch has already waited out the streak limit.
  assign starve_c   = (streak_q == CNT_W'(STARVE_LIM));
  assign grant_dm_c = !reset && (state_q == IDLE) && bus.dm_req
                      && !(bus.if_req && starve_c);
  assign grant_if_c = !reset && (state_q == IDLE) && bus.if_req && !grant_dm_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      streak_q    <= '0;
      lat_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      streak_q    <= streak_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Next-state and registered-output logic; mem_* are loaded at grant so they
  // present the captured request during ISSUE and hold afterwards.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    streak_d    = streak_q;
    lat_cnt_d   = lat_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_dm_c) begin
          state_d     = ISSUE;
          owner_d     = OWN_DM;
          we_d        = bus.dm_we;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          if (!bus.if_req) begin
            streak_d = '0;
          end else if (!starve_c) begin
            streak_d = streak_q + CNT_W'(1);
          end
        end else if (grant_if_c) begin
          state_d     = ISSUE;
          owner_d     = OWN_IF;
          we_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      ISSUE: begin
        lat_cnt_d = CNT_W'(MEM_LAT - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = we_q ? '0 : bus.mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.if_gnt    = grant_if_c;
  assign bus.dm_gnt    = grant_dm_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic conflict_c;

  assign conflict_c = (state_q == IDLE) && bus.if_req && bus.dm_req;

  sat_counter32 u_perf_if_gnts (
    .clk   (clk),
    .reset (reset),
    .en    (grant_if_c),
    .count (perf_if_gnts)
  );

  sat_counter32 u_perf_dm_gnts (
    .clk   (clk),
    .reset (reset),
    .en    (grant_dm_c),
    .count (perf_dm_gnts)
  );

  sat_counter32 u_perf_conflicts (
    .clk   (clk),
    .reset (reset),
    .en    (conflict_c),
    .count (perf_conflicts)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_LIM = 4;
  localparam logic [7:0]  CH_I       = "I";
  localparam logic [7:0]  CH_D       = "D";

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_bad;
  int   last_gnt;
  int   n_if_rv;
  int   n_dm_rv;
  int   exp_if_total;
  int   exp_dm_total;
  logic [31:0] last_if_exp;

  iss_t        exp_issue[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];
  logic [31:0] rd_pipe[MEM_LAT];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_if_gnts;
  logic [31:0] perf_dm_gnts;
  logic [31:0] perf_conflicts;
`endif

  mem_port_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .STARVE_LIM (STARVE_LIM),
    .AW         (32),
    .DW         (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus)
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    .perf_if_gnts   (perf_if_gnts),
    .perf_dm_gnts   (perf_dm_gnts),
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'h2002_0045;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: reads return rd_fn(addr) exactly MEM_LAT cycles after mem_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? rd_fn(bus.mem_addr) : 32'hBAD0_BAD0;
    for (int i = 1; i < int'(MEM_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  // Output monitor: issues and responses are popped from the scoreboard.
  always @(negedge clk) begin
    iss_t        e;
    logic [31:0] x;
    if (reset) begin
      chk("gnt_in_reset", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'd0);
    end
    if (bus.if_gnt || bus.dm_gnt) begin
      chk("gnt_onehot", 32'(bus.if_gnt) + 32'(bus.dm_gnt), 32'd1);
      last_gnt = cyc;
    end
    if (bus.mem_en) begin
      if (exp_issue.size() == 0) begin
        chk("issue_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_issue.pop_front();
        chk("issue_lat", 32'(cyc - last_gnt), 32'd1);
        chk("issue_we", 32'(bus.mem_we), 32'(e.we));
        chk("issue_addr", bus.mem_addr, e.addr);
        if (e.we) chk("issue_wdata", bus.mem_wdata, e.wdata);
      end
    end
    if (bus.if_rvalid) begin
      n_if_rv++;
      if (exp_if.size() == 0) begin
        chk("if_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        x = exp_if.pop_front();
        last_if_exp = x;
        chk("if_resp_lat", 32'(cyc - last_gnt), 32'(MEM_LAT + 2));
        chk("if_rdata", bus.if_rdata, x);
      end
    end
    if (bus.dm_rvalid) begin
      n_dm_rv++;
      if (exp_dm.size() == 0) begin
        chk("dm_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        x = exp_dm.pop_front();
        chk("dm_resp_lat", 32'(cyc - last_gnt), 32'(MEM_LAT + 2));
        chk("dm_rdata", bus.dm_rdata, x);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},    32'(bus.if_gnt),    32'd0);
    chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
    chk({tag, "_if_rdata"},  bus.if_rdata,       32'd0);
    chk({tag, "_dm_gnt"},    32'(bus.dm_gnt),    32'd0);
    chk({tag, "_dm_rvalid"}, 32'(bus.dm_rvalid), 32'd0);
    chk({tag, "_dm_rdata"},  bus.dm_rdata,       32'd0);
    chk({tag, "_mem_en"},    32'(bus.mem_en),    32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
  endtask

  // Holds requests per the expected grant order, checking order and spacing.
  // Must be entered one cycle after posedge with the arbiter idle.
  task automatic run(input string order, input logic [31:0] if_a0,
                     input logic [31:0] dm_a0, input logic st);
    int n_if = 0, n_dm = 0, ki = 0, kd = 0, ei = 0, ed = 0;
    int prev = 0, waited;
    logic [7:0]  c;
    logic [31:0] a;
    for (int i = 0; i < order.len(); i++) begin
      if (order.getc(i) == CH_I) begin
        a = if_a0 + 32'(4 * ei);
        exp_issue.push_back('{1'b0, a, 32'd0});
        exp_if.push_back(rd_fn(a));
        exp_if_total++;
        ei++;
      end else begin
        a = dm_a0 + 32'(4 * ed);
        exp_issue.push_back('{st, a, 32'hDEAD_BEEF ^ 32'(ed)});
        exp_dm.push_back(st ? 32'd0 : rd_fn(a));
        exp_dm_total++;
        ed++;
      end
    end
    n_if = ei;
    n_dm = ed;
    bus.if_req   = (n_if > 0);
    bus.if_addr  = if_a0;
    bus.dm_req   = (n_dm > 0);
    bus.dm_we    = st;
    bus.dm_addr  = dm_a0;
    bus.dm_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < order.len(); i++) begin
      waited = 0;
      @(negedge clk);
      while (!(bus.if_gnt || bus.dm_gnt) && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 100) begin
        chk("grant_timeout", 32'd1, 32'd0);
        break;
      end
      c = bus.if_gnt ? CH_I : CH_D;
      chk("grant_order", 32'(c), 32'(order.getc(i)));
      if (i == 0) chk("grant_wait", 32'(waited), 32'd0);
      else        chk("grant_gap", 32'(cyc - prev), 32'(MEM_LAT + 3));
      prev = cyc;
      @(posedge clk);
      #1;
      if (c == CH_I) begin
        ki++;
        if (ki >= n_if) bus.if_req = 1'b0;
        else            bus.if_addr = if_a0 + 32'(4 * ki);
      end else begin
        kd++;
        if (kd >= n_dm) bus.dm_req = 1'b0;
        else begin
          bus.dm_addr  = dm_a0 + 32'(4 * kd);
          bus.dm_wdata = 32'hDEAD_BEEF ^ 32'(kd);
        end
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    waited = 0;
    while ((exp_if.size() != 0 || exp_dm.size() != 0 || exp_issue.size() != 0)
           && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    cyc = 0;
    n_chk = 0;
    n_bad = 0;
    last_gnt = 0;
    n_if_rv = 0;
    n_dm_rv = 0;
    exp_if_total = 0;
    exp_dm_total = 0;
    last_if_exp = 32'd0;
    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = 32'd0;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    bus.dm_addr = 32'd0;
    bus.dm_wdata = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("perf_if_rst", perf_if_gnts, 32'd0);
    chk("perf_conf_rst", perf_conflicts, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Simultaneous requests: data first, fetch five cycles later.
    run("DI", 32'h0000_0080, 32'h0000_0140, 1'b0);
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("perf_dm_gnts", perf_dm_gnts, 32'd1);
    chk("perf_if_gnts", perf_if_gnts, 32'd1);
    chk("perf_conflicts", perf_conflicts, 32'd1);
`endif

    run("I", 32'h0000_0040, 32'd0, 1'b0);
    chk("fetch_0x40_data", last_if_exp, 32'h2002_0005);

    run("D", 32'd0, 32'h0000_0100, 1'b1);

    run("DDDDIDDDDIDD", 32'h0000_1000, 32'h0000_0200, 1'b0);
    chk("if_rdata_hold", bus.if_rdata, rd_fn(32'h0000_1004));

    // Load aborted by reset during WAIT; its response must never appear.
    exp_issue.push_back('{1'b0, 32'h0000_0300, 32'd0});
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_addr = 32'h0000_0300;
    @(negedge clk);
    chk("abort_dm_gnt", 32'(bus.dm_gnt), 32'd1);
    @(posedge clk);
    #1 bus.dm_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0500;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("abort");
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run("I", 32'h0000_0500, 32'd0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("if_resp_count", 32'(n_if_rv), 32'(exp_if_total));
    chk("dm_resp_count", 32'(n_dm_rv), 32'(exp_dm_total));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
